// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gol_pkg
// Description : Shared constants and types for the Game-of-Life display path.
// Revision    : 1.0 - initial release
// ============================================================================
package gol_pkg;

  // Default board geometry, border rows/columns included.
  localparam int GOL_HEIGHT = 20;
  localparam int GOL_WIDTH  = 20;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    BLANK = 2'd2,
    SHOW  = 2'd3
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/row_popcount.sv
`default_nettype none
// ============================================================================
// Module      : row_popcount
// Description : Combinational count of set bits in one board row.
// Revision    : 1.0 - initial release
// ============================================================================
module row_popcount #(
  parameter int WIDTH = 20
) (
  input  logic [0:WIDTH-1]             row,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Ripple sum of the row bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(row[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/board_scan.sv
`default_nettype none
// ============================================================================
// Module      : board_scan
// Description : Row-multiplexed LED scan of a snapshotted Game-of-Life board,
//               with per-row blanking and last-frame population count.
// Revision    : 1.0 - initial release
// ============================================================================
module board_scan #(
  parameter int HEIGHT = gol_pkg::GOL_HEIGHT,
  parameter int WIDTH  = gol_pkg::GOL_WIDTH,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 4,
  parameter int POP_W  = $clog2(HEIGHT * WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [0:HEIGHT-1][0:WIDTH-1]  board,
  output logic [0:HEIGHT-1]             row_sel,
  output logic [0:WIDTH-1]              col_data,
  output logic                          frame_start,
  output logic [POP_W-1:0]              population,
  output logic                          pop_valid
);

  import gol_pkg::*;

  // The parameter BLANK shadows the state literal of the same name, so state
  // literals are always written package-qualified in this file.

  localparam int ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PC_W    = $clog2(WIDTH + 1);

  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK - 1);

  scan_state_t                  state_q, state_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [0:HEIGHT-1][0:WIDTH-1] snap_q, snap_d;
  logic [POP_W-1:0]             acc_q, acc_d;
  logic                         frame_start_q, frame_start_d;
  logic [POP_W-1:0]             population_q, population_d;
  logic                         pop_valid_q, pop_valid_d;

  logic [ROW_W-1:0]             next_row;
  logic [0:WIDTH-1]             pc_row;
  logic [PC_W-1:0]              pc_count;

  assign next_row = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

  // Row whose popcount is added on the edge that enters SHOW. Without
  // blanking, SHOW is entered straight from SNAP (row 0 of the incoming
  // board) or from the previous SHOW row (the following snapshot row).
  always_comb begin
    pc_row = snap_q[row_q];
    case (state_q)
      gol_pkg::SNAP: pc_row = board[0];
      gol_pkg::SHOW: pc_row = snap_q[next_row];
      default:       pc_row = snap_q[row_q];
    endcase
  end

  row_popcount #(
    .WIDTH (WIDTH)
  ) u_row_popcount (
    .row   (pc_row),
    .count (pc_count)
  );

  // Next-state and next-register logic for the scan sequencer.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    cnt_d         = cnt_q;
    snap_d        = snap_q;
    acc_d         = acc_q;
    frame_start_d = 1'b0;
    population_d  = population_q;
    pop_valid_d   = pop_valid_q;

    if (!enable) begin
      // Dropping enable abandons the frame; the reported population stays.
      state_d = gol_pkg::IDLE;
      row_d   = '0;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        gol_pkg::IDLE: begin
          state_d = gol_pkg::SNAP;
        end
        gol_pkg::SNAP: begin
          snap_d        = board;
          row_d         = '0;
          cnt_d         = '0;
          frame_start_d = 1'b1;
          if (BLANK == 0) begin
            state_d = gol_pkg::SHOW;
            acc_d   = POP_W'(pc_count);
          end else begin
            state_d = gol_pkg::BLANK;
            acc_d   = '0;
          end
        end
        gol_pkg::BLANK: begin
          if (cnt_q == BLANK_END) begin
            state_d = gol_pkg::SHOW;
            cnt_d   = '0;
            acc_d   = acc_q + POP_W'(pc_count);
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
        gol_pkg::SHOW: begin
          if (cnt_q == DWELL_END) begin
            cnt_d = '0;
            if (row_q == LAST_ROW) begin
              population_d = acc_q;
              pop_valid_d  = 1'b1;
              state_d      = gol_pkg::SNAP;
            end else begin
              row_d = next_row;
              if (BLANK == 0) begin
                state_d = gol_pkg::SHOW;
                acc_d   = acc_q + POP_W'(pc_count);
              end else begin
                state_d = gol_pkg::BLANK;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = gol_pkg::IDLE;
        end
      endcase
    end
  end

  // Sequencer registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= gol_pkg::IDLE;
      row_q         <= '0;
      cnt_q         <= '0;
      snap_q        <= '0;
      acc_q         <= '0;
      frame_start_q <= 1'b0;
      population_q  <= '0;
      pop_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      snap_q        <= snap_d;
      acc_q         <= acc_d;
      frame_start_q <= frame_start_d;
      population_q  <= population_d;
      pop_valid_q   <= pop_valid_d;
    end
  end

  // One-hot row drive, decoded from registered state only.
  for (genvar i = 0; i < HEIGHT; i++) begin : g_row_sel
    assign row_sel[i] = (state_q == gol_pkg::SHOW) && (row_q == ROW_W'(i));
  end

  assign col_data    = (state_q == gol_pkg::SHOW) ? snap_q[row_q] : '0;
  assign frame_start = frame_start_q;
  assign population  = population_q;
  assign pop_valid   = pop_valid_q;

endmodule
`default_nettype wire
